// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES InvMixColumns stage.
package inv_mix_columns_iter_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for inv_mix_columns_iter; the bypass signal exists only with INV_MIX_BYPASS_EN.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds valid and data steady until that edge.
interface inv_mix_columns_iter_if;
  import inv_mix_columns_iter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] data_out;
  logic               busy;
  state_e             dbg_state;
`ifdef INV_MIX_BYPASS_EN
  logic               bypass;

  modport slave (
    input  in_valid, data_in, out_ready, bypass,
    output in_ready, out_valid, data_out, busy, dbg_state
  );
  modport master (
    output in_valid, data_in, out_ready, bypass,
    input  in_ready, out_valid, data_out, busy, dbg_state
  );
`else
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy, dbg_state
  );
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy, dbg_state
  );
`endif
endinterface

// File: rtl/inv_mix_columns_iter_single_column.sv
// Combinational InvMixColumns of one 32-bit column; row r lives in byte [8r+7:8r].
module inv_mix_single_column
  import inv_mix_columns_iter_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_i[7:0];
  assign b1 = col_i[15:8];
  assign b2 = col_i[23:16];
  assign b3 = col_i[31:24];

  assign col_o[7:0]   = gf_mule(b0) ^ gf_mulb(b1) ^ gf_muld(b2) ^ gf_mul9(b3);
  assign col_o[15:8]  = gf_mul9(b0) ^ gf_mule(b1) ^ gf_mulb(b2) ^ gf_muld(b3);
  assign col_o[23:16] = gf_muld(b0) ^ gf_mul9(b1) ^ gf_mule(b2) ^ gf_mulb(b3);
  assign col_o[31:24] = gf_mulb(b0) ^ gf_muld(b1) ^ gf_mul9(b2) ^ gf_mule(b3);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per cycle through a shared multiplier.
// Optional INV_MIX_BYPASS_EN adds a bypass input that skips the transform (final round).
module inv_mix_columns_iter
  import inv_mix_columns_iter_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  inv_mix_columns_iter_if.slave bus
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [COL_W-1:0]   col_in, col_out;
  logic               go_run;

  assign col_in = work_q[col_q*COL_W +: COL_W];

  inv_mix_single_column u_col (
    .col_i (col_in),
    .col_o (col_out)
  );

`ifdef INV_MIX_BYPASS_EN
  assign go_run = !bus.bypass;
`else
  assign go_run = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.data_in;
          col_d   = '0;
          state_d = go_run ? RUN : DONE;
        end
      end
      RUN: begin
        // Result overwrites its own column; later columns are still untouched input.
        work_d[col_q*COL_W +: COL_W] = col_out;
        if (col_q == CW'(NCOL - 1)) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.data_out  = work_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter using known AES column vectors.
module tb_inv_mix_columns_iter;
  import inv_mix_columns_iter_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  inv_mix_columns_iter_if bus ();

  inv_mix_columns_iter #(.NCOL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Known columns and their InvMixColumns images.
  localparam logic [31:0] C_ONE = 32'h01010101;
  localparam logic [31:0] C_C6  = 32'hC6C6C6C6;
  localparam logic [31:0] C_A   = 32'hBCA14D8E;
  localparam logic [31:0] R_A   = 32'h455313DB;
  localparam logic [31:0] C_B   = 32'h9D58DC9F;
  localparam logic [31:0] R_B   = 32'h5C220AF2;
  localparam logic [31:0] C_D   = 32'hD6D7D5D5;
  localparam logic [31:0] R_D   = 32'hD5D4D4D4;
  localparam logic [31:0] C_E   = 32'hF8BD7E4D;
  localparam logic [31:0] R_E   = 32'h4C31262D;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] d);
    bus.data_in  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  logic [127:0] s_in  [3];
  logic [127:0] s_exp [3];
  logic [127:0] held;
  int           n;
  int           acc;
  int           outn;
  int           last_cyc;
  logic         acc_now;

  initial begin
    s_in[0]  = {C_B, C_A, C_C6, C_ONE};
    s_exp[0] = {R_B, R_A, C_C6, C_ONE};
    s_in[1]  = {C_E, C_D, C_B, C_A};
    s_exp[1] = {R_E, R_D, R_B, R_A};
    s_in[2]  = {C_ONE, C_E, C_A, C_D};
    s_exp[2] = {C_ONE, R_E, R_A, R_D};

    // Reset values.
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
`ifdef INV_MIX_BYPASS_EN
    bus.bypass    = 1'b0;
`endif
    tick();
    tick();
    chk("rst_data_out", bus.data_out, 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_state", 128'(bus.dbg_state), 128'(IDLE));
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

    // Single known column, latency of 4 cycles after the accept edge.
    accept({C_ONE, C_ONE, C_ONE, C_A});
    bus.data_in = {4{32'hDEADBEEF}};
    chk("run_busy", 128'(bus.busy), 128'd1);
    chk("run_in_ready", 128'(bus.in_ready), 128'd0);
    wait_done(n);
    chk("latency", 128'(n), 128'd4);
    chk("single_col", bus.data_out, {C_ONE, C_ONE, C_ONE, R_A});
    chk("done_busy", 128'(bus.busy), 128'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("single_drain", 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;

    // Full state under backpressure, with an ignored input pulse.
    accept(s_in[0]);
    wait_done(n);
    chk("full_latency", 128'(n), 128'd4);
    held = bus.data_out;
    chk("full_state", held, s_exp[0]);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.data_in  = {4{32'h12345678}};
      end
      if (i == 4) bus.in_valid = 1'b0;
      chk("bp_data", bus.data_out, s_exp[0]);
      chk("bp_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 128'(bus.out_valid), 128'd0);
    chk("bp_release_idle", 128'(bus.dbg_state), 128'(IDLE));
    chk("bp_release_ready", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b0;
    tick();
    chk("bp_no_accept", 128'(bus.dbg_state), 128'(IDLE));

    // Reset in the middle of a run, then a clean transfer.
    accept(s_in[1]);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_data", bus.data_out, 128'd0);
    chk("midrst_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    tick();
    rst = 1'b0;
    tick();
    accept(s_in[2]);
    wait_done(n);
    chk("postrst_latency", 128'(n), 128'd4);
    chk("postrst_data", bus.data_out, s_exp[2]);
    bus.out_ready = 1'b1;
    tick();
    chk("postrst_drain", 128'(bus.out_valid), 128'd0);

    // Back-to-back streaming with both handshakes held high.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.data_in   = s_in[0];
    acc      = 0;
    outn     = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && outn < 3; cyc++) begin
      acc_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        chk("b2b_data", bus.data_out, s_exp[outn]);
        if (outn > 0) chk("b2b_spacing", 128'(cyc - last_cyc), 128'd6);
        last_cyc = cyc;
        outn++;
      end
      tick();
      if (acc_now) begin
        acc++;
        if (acc < 3) bus.data_in = s_in[acc];
        else bus.in_valid = 1'b0;
      end
    end
    chk("b2b_count", 128'(outn), 128'd3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();

`ifdef INV_MIX_BYPASS_EN
    // Bypass: one-cycle pass-through, never busy.
    bus.bypass   = 1'b1;
    bus.data_in  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    bus.in_valid = 1'b1;
    chk("byp_busy_pre", 128'(bus.busy), 128'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    chk("byp_valid", 128'(bus.out_valid), 128'd1);
    chk("byp_data", bus.data_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("byp_busy", 128'(bus.busy), 128'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("byp_drain", 128'(bus.out_valid), 128'd0);
    chk("byp_busy_post", 128'(bus.busy), 128'd0);
    bus.out_ready = 1'b0;
    bus.bypass    = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
Name: inv_mix_columns_iter

Overview:
- Iterative AES InvMixColumns stage for the decryption datapath.
- Accepts a 128-bit state, transforms one 32-bit column per cycle through a single shared column multiplier, and presents the 128-bit result.
- Sits between InvAddRoundKey (upstream) and InvShiftRows/InvSubBytes (downstream).
- Uses valid/ready handshakes on both sides so the round controller can stall it.

Parameters:
- NCOL, 4, number of 32-bit columns in the state. Fixed at 4 for AES; used for counter width and loop bounds only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream state on data_in is valid
- in_ready  output  1  block can accept a state
- data_in  input  128  input state; column c at [32c+31:32c]; row r of a column at byte [8r+7:8r]
- out_valid  output  1  data_out holds a completed result
- out_ready  input  1  downstream accepts the result
- data_out  output  128  InvMixColumns(data_in), same layout as data_in
- busy  output  1  high while columns are being processed

Behaviour:
- Reset (async, rst=1): state=IDLE, col_cnt=0, working register=0, data_out=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register data_in into the working register, set col_cnt=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, column col_cnt of the working register passes through the column multiplier. The result replaces that column in place, and col_cnt increments.
  - When col_cnt==NCOL-1 completes, go to DONE.
  - Column order is 0,1,2,3.
- Column multiplier, per output row r of an input column (b0..b3 = rows 0..3):
  - row0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
  - row1 = 09·b0 ^ 0e·b1 ^ 0b·b2 ^ 0d·b3
  - row2 = 0d·b0 ^ 09·b1 ^ 0e·b2 ^ 0b·b3
  - row3 = 0b·b0 ^ 0d·b1 ^ 09·b2 ^ 0e·b3
  - All multiplications are in GF(2^8) modulo x^8+x^4+x^3+x+1. Every product byte is a full 8-bit value from a full 8-bit input byte.
- DONE:
  - out_valid=1 and data_out equals the working register.
  - data_out is stable while out_valid&!out_ready.
  - On out_ready, out_valid falls next cycle and the state returns to IDLE.
  - in_ready stays 0 in DONE; no overlap of input acceptance with output transfer.
- Latency: accept edge to out_valid high is 4 cycles after the accept edge (NCOL cycles). Throughput is one state per 6 cycles with out_ready held at 1.
- in_valid while not ready is ignored. data_in is sampled only on the accept edge; later changes to data_in have no effect.
- out_ready while out_valid=0 has no effect.
- Reset mid-RUN or mid-DONE aborts immediately: the partial result is discarded and all outputs return to reset values.
- col_cnt wraps to 0 on the transition to DONE.

Optional Feature:
- Macro: INV_MIX_BYPASS_EN.
- With the macro defined:
  - Adds input port bypass (1 bit), sampled with data_in on the accept edge.
  - If bypass=1, the state skips RUN and goes IDLE→DONE with data_out=data_in unmodified (1-cycle latency). This serves the final decryption round, which omits InvMixColumns.
  - busy stays 0 for a bypassed transfer.
- Without the macro: no bypass port, and every accepted state takes the RUN path.

Decomposition:
- Shared package/header holds:
  - STATE_W=128 and COL_W=32.
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The reduction polynomial constant 8'h1B.
- One sub-module, inv_mix_single_column: combinational 32-bit-in/32-bit-out column transform built from the existing per-row inverse multipliers.
- The sequential wrapper instantiates exactly one inv_mix_single_column and muxes the column via col_cnt.

Test Plan:
- Known vector, single column: data_in column0 = 32'hBCA14D8E (rows 8e,4d,a1,bc), other columns 32'h01010101 → data_out column0 = 32'h455313DB, others 32'h01010101, out_valid exactly 4 cycles after accept.
- Full state: columns {32'h9D58DC9F, 32'hBCA14D8E, 32'hC6C6C6C6, 32'h01010101} (col3..col0) → {32'h5C220AF2, 32'h455313DB, 32'hC6C6C6C6, 32'h01010101}.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → data_out constant, out_valid=1, in_ready=0, a second in_valid pulse is ignored. Then out_ready=1 → one transfer, IDLE next cycle.
- Reset mid-RUN: assert rst when col_cnt=2 → next sample data_out=0, out_valid=0, busy=0. After release, a fresh accept produces the correct result with no stale columns.
- Back-to-back: in_valid and out_ready held high, three distinct states → three correct results, each spaced 6 cycles, none dropped or duplicated.
- INV_MIX_BYPASS_EN build, bypass=1 with data_in=128'h00112233_44556677_8899AABB_CCDDEEFF → out_valid next cycle, data_out identical, busy never high.
